// File: rtl/atuador_porta.sv
// Revolving-door actuator: debounces sensor status codes and drives
// motor, lock, alarm and busy outputs with timed actuations.
module atuador_porta #(
  parameter int DEBOUNCE     = 4,
  parameter int ROT_CYCLES   = 50,
  parameter int ALARM_CYCLES = 100,
  parameter int BLINK_HALF   = 10,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ledVerde,
  input  logic [1:0] ledVermelho,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic       trava,
  output logic       alarme,
  output logic       ocupado,
  output logic       erro
);

  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_ENTRA = 4'b0100;
  localparam logic [3:0] C_METAL = 4'b0001;
  localparam logic [3:0] C_SAI   = 4'b1010;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] ROT_LAST = CNT_W'(ROT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALM_LAST = CNT_W'(ALARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    REPOUSO,
    GIRA_FRENTE,
    GIRA_TRAS,
    ALARME,
    ESPERA
  } state_t;

  logic [3:0]       code_in;
  logic [3:0]       code_q;
  logic [3:0]       stable_q;
  logic [CNT_W-1:0] deb_q;
  logic             accept_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic             ph_q, ph_d;

  logic motor_fwd_q, motor_fwd_d;
  logic motor_rev_q, motor_rev_d;
  logic trava_q, trava_d;
  logic alarme_q, alarme_d;
  logic ocupado_q, ocupado_d;
  logic erro_q, erro_d;

  logic is_ent, is_sai, is_met, is_inv, is_rest;

  assign code_in = {ledVerde, ledVermelho};

  assign is_ent  = (stable_q == C_ENTRA);
  assign is_sai  = (stable_q == C_SAI);
  assign is_met  = (stable_q == C_METAL);
  assign is_inv  = !(is_ent || is_sai || is_met ||
                     stable_q == C_IDLE);
  assign is_rest = !(is_ent || is_sai || is_met);

  // Register the code, count stable cycles, pulse accept once per code
  always_ff @(posedge clock) begin
    if (reset) begin
      code_q   <= C_IDLE;
      stable_q <= C_IDLE;
      deb_q    <= '0;
      accept_q <= 1'b0;
    end else if (code_in != code_q) begin
      code_q   <= code_in;
      deb_q    <= ONE;
      accept_q <= (DEBOUNCE == 1);
      if (DEBOUNCE == 1) stable_q <= code_in;
    end else if (deb_q < DEB_MAX) begin
      deb_q    <= deb_q + ONE;
      accept_q <= (deb_q == DEB_LAST);
      if (deb_q == DEB_LAST) stable_q <= code_q;
    end else begin
      accept_q <= 1'b0;
    end
  end

  // State, timers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= REPOUSO;
      tmr_q       <= '0;
      blk_q       <= '0;
      ph_q        <= 1'b0;
      motor_fwd_q <= 1'b0;
      motor_rev_q <= 1'b0;
      trava_q     <= 1'b1;
      alarme_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      blk_q       <= blk_d;
      ph_q        <= ph_d;
      motor_fwd_q <= motor_fwd_d;
      motor_rev_q <= motor_rev_d;
      trava_q     <= trava_d;
      alarme_q    <= alarme_d;
      ocupado_q   <= ocupado_d;
      erro_q      <= erro_d;
    end
  end

  // Next state and timer updates from the accepted code
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    blk_d   = blk_q;
    ph_d    = ph_q;
    unique case (state_q)
      REPOUSO: begin
        if (accept_q && is_ent) begin
          state_d = GIRA_FRENTE;
          tmr_d   = '0;
        end else if (accept_q && is_sai) begin
          state_d = GIRA_TRAS;
          tmr_d   = '0;
        end else if (accept_q && is_met) begin
          state_d = ALARME;
          tmr_d   = '0;
          blk_d   = '0;
          ph_d    = 1'b1;
        end
      end
      GIRA_FRENTE, GIRA_TRAS: begin
        if (accept_q && is_met) begin
          state_d = ALARME;
          tmr_d   = '0;
          blk_d   = '0;
          ph_d    = 1'b1;
        end else if (tmr_q == ROT_LAST) begin
          state_d = ESPERA;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + ONE;
        end
      end
      ALARME: begin
        if (accept_q && is_met) begin
          tmr_d = '0;
          blk_d = '0;
          ph_d  = 1'b1;
        end else if (tmr_q == ALM_LAST) begin
          state_d = ESPERA;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + ONE;
          if (blk_q == BLK_LAST) begin
            blk_d = '0;
            ph_d  = ~ph_q;
          end else begin
            blk_d = blk_q + ONE;
          end
        end
      end
      ESPERA: begin
        if (is_rest) state_d = REPOUSO;
      end
      default: begin
        state_d = REPOUSO;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register with it
  always_comb begin
    motor_fwd_d = (state_d == GIRA_FRENTE);
    motor_rev_d = (state_d == GIRA_TRAS);
    trava_d     = !(state_d == GIRA_FRENTE ||
                    state_d == GIRA_TRAS);
    alarme_d    = (state_d == ALARME) && ph_d;
    ocupado_d   = (state_d != REPOUSO);
    erro_d      = accept_q && is_inv;
  end

  assign motor_fwd = motor_fwd_q;
  assign motor_rev = motor_rev_q;
  assign trava     = trava_q;
  assign alarme    = alarme_q;
  assign ocupado   = ocupado_q;
  assign erro      = erro_q;

endmodule
